// File: rtl/pingpong_pkg.sv
// Shared types for the ping-pong BRAM write controller.
// Bank index, per-bank status encoding and frame counter width.
package pingpong_pkg;

    typedef logic bank_t;

    typedef enum logic [1:0] {
        B_EMPTY,
        B_PEND,
        B_FULL
    } bank_st_t;

    localparam int FRAME_CNT_W = 16;

endpackage

// File: rtl/pingpong_bank_state.sv
// Per-bank status tracker: EMPTY -> PEND -> FULL -> EMPTY.
// Captures the fill length when the bank is closed.
module pingpong_bank_state
    import pingpong_pkg::*;
#(
    parameter int LEN_W = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             close_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             release_i,
    output logic             pend_o,
    output logic             full_o,
    output logic [LEN_W-1:0] len_o
);

    bank_st_t         state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= B_EMPTY;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        unique case (state_q)
            B_EMPTY: begin
                if (close_i) begin
                    state_d = B_PEND;
                    len_d   = len_i;
                end
            end
            B_PEND:  state_d = B_FULL;
            B_FULL: begin
                if (release_i) state_d = B_EMPTY;
            end
            default: state_d = B_EMPTY;
        endcase
    end

    assign pend_o = (state_q == B_PEND);
    assign full_o = (state_q == B_FULL);
    assign len_o  = len_q;

endmodule

// File: rtl/pingpong_bram_ctrl.sv
// Ping-pong write controller: fills BRAM bank 0 then bank 1 from a
// valid/ready stream and holds each filled bank until the reader releases it.
module pingpong_bram_ctrl
    import pingpong_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [DATA_W-1:0]      in_data,
    input  logic                   in_last,
    output logic                   in_ready,
    output logic                   wr_en_0,
    output logic [ADDR_W-1:0]      wr_addr_0,
    output logic [DATA_W-1:0]      wr_data_0,
    output logic                   wr_en_1,
    output logic [ADDR_W-1:0]      wr_addr_1,
    output logic [DATA_W-1:0]      wr_data_1,
    output logic                   buf_valid,
    output logic                   buf_bank,
    output logic [ADDR_W:0]        buf_len,
    input  logic                   buf_done,
    output logic                   err_done,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    localparam int LEN_W = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    bank_t                  wbank_q, wbank_d;
    bank_t                  rbank_q, rbank_d;
    logic [ADDR_W-1:0]      wcount_q, wcount_d;
    logic [FRAME_CNT_W-1:0] frame_q, frame_d;
    logic                   err_q, err_d;

    logic                   wen0_q, wen0_d;
    logic                   wen1_q, wen1_d;
    logic [ADDR_W-1:0]      waddr0_q, waddr0_d;
    logic [ADDR_W-1:0]      waddr1_q, waddr1_d;
    logic [DATA_W-1:0]      wdata0_q, wdata0_d;
    logic [DATA_W-1:0]      wdata1_q, wdata1_d;

    logic [1:0]             pend, full;
    logic [1:0]             close_b, rel_b;
    logic [LEN_W-1:0]       len0, len1;
    logic [LEN_W-1:0]       close_len;
    logic                   accept, closing;

    assign in_ready  = !full[wbank_q] && !pend[wbank_q];
    assign accept    = in_valid && in_ready;
    assign closing   = in_last || (wcount_q == LAST_IDX);
    assign close_len = LEN_W'(wcount_q) + LEN_W'(1);

    assign buf_valid = full[rbank_q];
    assign buf_bank  = rbank_q;
    assign buf_len   = rbank_q ? len1 : len0;

    assign close_b[0] = accept && closing && (wbank_q == 1'b0);
    assign close_b[1] = accept && closing && (wbank_q == 1'b1);
    assign rel_b[0]   = buf_done && buf_valid && (rbank_q == 1'b0);
    assign rel_b[1]   = buf_done && buf_valid && (rbank_q == 1'b1);

    pingpong_bank_state #(.LEN_W(LEN_W)) u_bank0 (
        .clk       (clk),
        .rst       (rst),
        .close_i   (close_b[0]),
        .len_i     (close_len),
        .release_i (rel_b[0]),
        .pend_o    (pend[0]),
        .full_o    (full[0]),
        .len_o     (len0)
    );

    pingpong_bank_state #(.LEN_W(LEN_W)) u_bank1 (
        .clk       (clk),
        .rst       (rst),
        .close_i   (close_b[1]),
        .len_i     (close_len),
        .release_i (rel_b[1]),
        .pend_o    (pend[1]),
        .full_o    (full[1]),
        .len_o     (len1)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wbank_q  <= 1'b0;
            rbank_q  <= 1'b0;
            wcount_q <= '0;
            frame_q  <= '0;
            err_q    <= 1'b0;
            wen0_q   <= 1'b0;
            wen1_q   <= 1'b0;
            waddr0_q <= '0;
            waddr1_q <= '0;
            wdata0_q <= '0;
            wdata1_q <= '0;
        end else begin
            wbank_q  <= wbank_d;
            rbank_q  <= rbank_d;
            wcount_q <= wcount_d;
            frame_q  <= frame_d;
            err_q    <= err_d;
            wen0_q   <= wen0_d;
            wen1_q   <= wen1_d;
            waddr0_q <= waddr0_d;
            waddr1_q <= waddr1_d;
            wdata0_q <= wdata0_d;
            wdata1_q <= wdata1_d;
        end
    end

    always_comb begin
        wbank_d  = wbank_q;
        rbank_d  = rbank_q;
        wcount_d = wcount_q;
        frame_d  = frame_q;
        err_d    = err_q;
        wen0_d   = 1'b0;
        wen1_d   = 1'b0;
        waddr0_d = waddr0_q;
        waddr1_d = waddr1_q;
        wdata0_d = wdata0_q;
        wdata1_d = wdata1_q;

        if (accept) begin
            if (wbank_q == 1'b0) begin
                wen0_d   = 1'b1;
                waddr0_d = wcount_q;
                wdata0_d = in_data;
            end else begin
                wen1_d   = 1'b1;
                waddr1_d = wcount_q;
                wdata1_d = in_data;
            end
            if (closing) begin
                wbank_d  = ~wbank_q;
                wcount_d = '0;
            end else begin
                wcount_d = wcount_q + ADDR_W'(1);
            end
        end

        // A release with nothing offered is dropped but flagged.
        if (buf_done) begin
            if (buf_valid) begin
                rbank_d = ~rbank_q;
                frame_d = frame_q + FRAME_CNT_W'(1);
            end else begin
                err_d = 1'b1;
            end
        end
    end

    assign wr_en_0   = wen0_q;
    assign wr_addr_0 = waddr0_q;
    assign wr_data_0 = wdata0_q;
    assign wr_en_1   = wen1_q;
    assign wr_addr_1 = waddr1_q;
    assign wr_data_1 = wdata1_q;
    assign err_done  = err_q;
    assign frame_cnt = frame_q;

endmodule
